// File: rtl/normalize_mixer.sv
`default_nettype none
// normalize_mixer: AXI4-Lite programmable weighted mixer. A serial MAC computes sat((sum lane[k]*W[k]) >>> SHIFT).
// Optional feature: NORMALIZE_CLIP_COUNT_EN enables the STATUS[15:0] saturation counter. Rev 1.0

module normalize_mixer #(
    parameter int NUM_CH               = 8,
    parameter int SAMPLE_W             = 16,
    parameter int C_S00_AXI_DATA_WIDTH = 32,
    parameter int C_S00_AXI_ADDR_WIDTH = 7
) (
    input  logic                                s00_axi_aclk,
    input  logic                                s00_axi_aresetn,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [2:0]                          s00_axi_awprot,
    input  logic                                s00_axi_awvalid,
    output logic                                s00_axi_awready,
    input  logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [C_S00_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                                s00_axi_wvalid,
    output logic                                s00_axi_wready,
    output logic [1:0]                          s00_axi_bresp,
    output logic                                s00_axi_bvalid,
    input  logic                                s00_axi_bready,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [2:0]                          s00_axi_arprot,
    input  logic                                s00_axi_arvalid,
    output logic                                s00_axi_arready,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                          s00_axi_rresp,
    output logic                                s00_axi_rvalid,
    input  logic                                s00_axi_rready,
    input  logic [NUM_CH*SAMPLE_W-1:0]          s_axis_tdata,
    input  logic                                s_axis_tvalid,
    output logic                                s_axis_tready,
    output logic [SAMPLE_W-1:0]                 m_axis_tdata,
    output logic                                m_axis_tvalid,
    input  logic                                m_axis_tready
);

    localparam int ACC_W = 2*SAMPLE_W + $clog2(NUM_CH);
    localparam int K_W   = $clog2(NUM_CH);
    localparam int IDX_W = C_S00_AXI_ADDR_WIDTH - 2;
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, OUT = 2'd2} state_t;
    state_t state, state_nx;

    logic                       aw_rdy, b_vld, ar_rdy, r_vld;
    logic [31:0]                r_data, rd_mux;
    logic                       en;
    logic [4:0]                 shift;
    logic [SAMPLE_W-1:0]        weight [NUM_CH];
    logic [NUM_CH*SAMPLE_W-1:0] lanes;
    logic [K_W-1:0]             k;
    logic                       last, accept, wr_en;
    logic signed [2*SAMPLE_W-1:0] prod;
    logic signed [ACC_W-1:0]    acc, acc_nx, shifted;
    logic [SAMPLE_W-1:0]        sat_data, out_data;
    logic                       clip;
    logic [15:0]                clip_cnt;
    logic [IDX_W-1:0]           wr_idx, rd_idx;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v, input logic [31:0] new_v,
                                                input logic [3:0] strb);
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            r[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
        return r;
    endfunction

    assign wr_idx = s00_axi_awaddr[C_S00_AXI_ADDR_WIDTH-1:2];
    assign rd_idx = s00_axi_araddr[C_S00_AXI_ADDR_WIDTH-1:2];
    assign wr_en  = aw_rdy & s00_axi_awvalid & s00_axi_wvalid;

    assign s00_axi_awready = aw_rdy;
    assign s00_axi_wready  = aw_rdy;
    assign s00_axi_bvalid  = b_vld;
    assign s00_axi_bresp   = 2'b00;
    assign s00_axi_arready = ar_rdy;
    assign s00_axi_rvalid  = r_vld;
    assign s00_axi_rdata   = r_data;
    assign s00_axi_rresp   = 2'b00;
    assign m_axis_tdata    = out_data;

    logic unused_ok;
    assign unused_ok = &{1'b0, s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            aw_rdy <= 1'b0;
            b_vld  <= 1'b0;
            ar_rdy <= 1'b0;
            r_vld  <= 1'b0;
            r_data <= '0;
        end else begin
            aw_rdy <= s00_axi_awvalid & s00_axi_wvalid & ~b_vld & ~aw_rdy;
            if (wr_en)               b_vld <= 1'b1;
            else if (s00_axi_bready) b_vld <= 1'b0;
            ar_rdy <= s00_axi_arvalid & ~r_vld & ~ar_rdy;
            if (ar_rdy && s00_axi_arvalid) begin
                r_vld  <= 1'b1;
                r_data <= rd_mux;
            end else if (s00_axi_rready) begin
                r_vld  <= 1'b0;
            end
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            en    <= 1'b0;
            shift <= 5'd15;
            for (int i = 0; i < NUM_CH; i++) weight[i] <= '0;
        end else if (wr_en) begin
            if (int'(wr_idx) == 0 && s00_axi_wstrb[0]) en <= s00_axi_wdata[0];
            if (int'(wr_idx) == 2) shift <= 5'(merge_bytes(32'(shift), s00_axi_wdata, s00_axi_wstrb));
            for (int i = 0; i < NUM_CH; i++)
                if (int'(wr_idx) == 4 + i)
                    weight[i] <= SAMPLE_W'(merge_bytes(32'(weight[i]), s00_axi_wdata, s00_axi_wstrb));
        end
    end

    always_comb begin
        rd_mux = '0;
        if (int'(rd_idx) == 0) rd_mux = {31'd0, en};
        if (int'(rd_idx) == 1) rd_mux = {(state != IDLE), 15'd0, clip_cnt};
        if (int'(rd_idx) == 2) rd_mux = {27'd0, shift};
        if (int'(rd_idx) == 3) rd_mux = 32'h0002_0000 | 32'(NUM_CH);
        for (int i = 0; i < NUM_CH; i++)
            if (int'(rd_idx) == 4 + i) rd_mux = 32'(weight[i]);
    end

    // Weights are indexed live by k, so a mid-frame write only reaches lanes not yet consumed.
    assign last    = (k == K_W'(NUM_CH-1));
    assign prod    = $signed(lanes[int'(k)*SAMPLE_W +: SAMPLE_W]) * $signed(weight[k]);
    assign acc_nx  = acc + {{(ACC_W-2*SAMPLE_W){prod[2*SAMPLE_W-1]}}, prod};
    assign shifted = acc_nx >>> shift;

    always_comb begin
        clip     = 1'b0;
        sat_data = shifted[SAMPLE_W-1:0];
        if (shifted > SAT_MAX) begin
            clip     = 1'b1;
            sat_data = SAT_MAX[SAMPLE_W-1:0];
        end else if (shifted < SAT_MIN) begin
            clip     = 1'b1;
            sat_data = SAT_MIN[SAMPLE_W-1:0];
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) state <= IDLE;
        else                  state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        accept        = 1'b0;
        case (state)
            IDLE: begin
                s_axis_tready = en;
                accept        = en & s_axis_tvalid;
                if (accept) state_nx = MAC;
            end
            MAC:  if (last) state_nx = OUT;
            OUT: begin
                m_axis_tvalid = 1'b1;
                if (m_axis_tready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            lanes    <= '0;
            acc      <= '0;
            k        <= '0;
            out_data <= '0;
        end else if (state == IDLE && accept) begin
            lanes <= s_axis_tdata;
            acc   <= '0;
            k     <= '0;
        end else if (state == MAC) begin
            acc <= acc_nx;
            k   <= k + 1'b1;
            if (last) out_data <= sat_data;
        end
    end

`ifdef NORMALIZE_CLIP_COUNT_EN
    logic clr;
    assign clr = wr_en & (int'(wr_idx) == 0) & s00_axi_wstrb[0] & s00_axi_wdata[1];

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn)                                   clip_cnt <= '0;
        else if (clr)                                           clip_cnt <= '0;
        else if (state == MAC && last && clip && clip_cnt != 16'hFFFF) clip_cnt <= clip_cnt + 16'd1;
    end
`else
    assign clip_cnt = '0;
`endif

endmodule

`default_nettype wire
